// File: rtl/cpu_bus_pkg.sv
// cpu_bus_pkg
//   Shared definitions for the 8088 bus front-end:
//   - busState_t   : bus-cycle FSM encoding (IDLE/ADDR/WAIT/DONE)
//   - STB_*        : bit positions of the qualified strobes in the strobe vector
//   - TIMEOUT_RD_BIT : value replicated across the read bus on a forced completion
package cpu_bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } busState_t;

  localparam int STB_MEMR = 0;
  localparam int STB_MEMW = 1;
  localparam int STB_IOR  = 2;
  localparam int STB_IOW  = 3;
  localparam int NUM_STB  = 4;

  // A timed-out read returns all ones, like an undriven pulled-up bus.
  localparam logic TIMEOUT_RD_BIT = 1'b1;

endpackage

// File: rtl/cpu_bus_region_match.sv
// cpu_bus_region_match
//   One region comparator: hit when every masked address bit equals the base
//   and the cycle type (IO vs memory) matches the region's space.
// Ports:
//   addr  in  ADDR_W  address being latched
//   ioM   in  1       1 = IO cycle, 0 = memory cycle
//   base  in  ADDR_W  region base address
//   mask  in  ADDR_W  1 = bit takes part in the compare
//   isIo  in  1       region lives in IO space
//   hit   out 1       region matches
module cpu_bus_region_match #(
  parameter int ADDR_W = 20
) (
  input  logic [ADDR_W-1:0] addr,
  input  logic              ioM,
  input  logic [ADDR_W-1:0] base,
  input  logic [ADDR_W-1:0] mask,
  input  logic              isIo,
  output logic              hit
);

  assign hit = (((addr ^ base) & mask) == '0) && (isIo == ioM);

endmodule

// File: rtl/cpu_bus_decoder.sv
// cpu_bus_decoder
//   Bus front-end between the 8088 core and its memory/IO slaves. Latches the
//   multiplexed address on ALE, decodes it against a runtime region map into a
//   one-hot select (lowest region index wins) or the default select, qualifies
//   the CPU strobes, stretches READY for per-region wait states and slave
//   handshakes, and registers read data back to the CPU.
// Build option:
//   BUS_TIMEOUT_EN  - when defined, a WAIT lasting TIMEOUT cycles is forced to
//                     complete, pulses oTimeout and returns all-ones read data.
// Ports:
//   iClk, iRst                 clock, synchronous active-high reset
//   iAle, iAd, iIoM            address latch enable, address/data, IO/mem
//   iRdN, iWrN, iDen, iDtr     CPU strobes (active-low) and data enable/direction
//   iRegBase/Mask/Io/Wait      per-region map
//   iSlvReady, iSlvData        per-region slave handshake and read data
//   iDefData                   default-region read data
//   oAddr, oWrData             latched address, write data
//   oSel, oDefSel              one-hot region select, no-hit select
//   oMemR/oMemW/oIoR/oIoW      qualified strobes (combinational)
//   oReady, oRdData, oTimeout  READY to CPU, registered read data, timeout pulse
module cpu_bus_decoder
  import cpu_bus_pkg::*;
#(
  parameter int ADDR_W      = 20,
  parameter int DATA_W      = 8,
  parameter int NUM_REGIONS = 4,
  parameter int WAIT_W      = 4,
  parameter int TIMEOUT     = 255
) (
  input  logic                                iClk,
  input  logic                                iRst,
  input  logic                                iAle,
  input  logic [ADDR_W-1:0]                   iAd,
  input  logic                                iIoM,
  input  logic                                iRdN,
  input  logic                                iWrN,
  input  logic                                iDen,
  input  logic                                iDtr,
  input  logic [NUM_REGIONS-1:0][ADDR_W-1:0]  iRegBase,
  input  logic [NUM_REGIONS-1:0][ADDR_W-1:0]  iRegMask,
  input  logic [NUM_REGIONS-1:0]              iRegIo,
  input  logic [NUM_REGIONS-1:0][WAIT_W-1:0]  iRegWait,
  input  logic [NUM_REGIONS-1:0]              iSlvReady,
  input  logic [NUM_REGIONS-1:0][DATA_W-1:0]  iSlvData,
  input  logic [DATA_W-1:0]                   iDefData,
  output logic [ADDR_W-1:0]                   oAddr,
  output logic [DATA_W-1:0]                   oWrData,
  output logic [NUM_REGIONS-1:0]              oSel,
  output logic                                oDefSel,
  output logic                                oMemR,
  output logic                                oMemW,
  output logic                                oIoR,
  output logic                                oIoW,
  output logic                                oReady,
  output logic [DATA_W-1:0]                   oRdData,
  output logic                                oTimeout
);

  busState_t          state, stateNext;
  logic [WAIT_W-1:0]  cnt;
  logic [NUM_STB-1:0] strb;
  logic               strbAct, strbPrev, strbRise, rdAct;
  logic               latch, startWait, forceDone, rdHold;

  // ---- strobes ----
  assign strb[STB_MEMR] = iDen & ~iIoM & ~iRdN;
  assign strb[STB_MEMW] = iDtr & ~iIoM & ~iWrN;
  assign strb[STB_IOR]  = iDen &  iIoM & ~iRdN;
  assign strb[STB_IOW]  = iDtr &  iIoM & ~iWrN;
  assign oMemR    = strb[STB_MEMR];
  assign oMemW    = strb[STB_MEMW];
  assign oIoR     = strb[STB_IOR];
  assign oIoW     = strb[STB_IOW];
  assign strbAct  = |strb;
  assign strbRise = strbAct & ~strbPrev;
  assign rdAct    = strb[STB_MEMR] | strb[STB_IOR];
  assign oWrData  = iAd[DATA_W-1:0];

  // ---- decode ----
  logic [NUM_REGIONS-1:0] hit, selNext;
  logic                   defNext;

  for (genvar g = 0; g < NUM_REGIONS; g++) begin : gMatch
    cpu_bus_region_match #(.ADDR_W(ADDR_W)) uMatch (
      .addr (iAd),
      .ioM  (iIoM),
      .base (iRegBase[g]),
      .mask (iRegMask[g]),
      .isIo (iRegIo[g]),
      .hit  (hit[g])
    );
  end

  // Isolate the lowest set bit: region 0 has highest priority.
  assign selNext = hit & (~hit + NUM_REGIONS'(1));
  assign defNext = ~|hit;

  // ---- per-selected-region muxes (no select at all behaves as default) ----
  logic [WAIT_W-1:0] selWait;
  logic [DATA_W-1:0] selData;
  logic              selRdy;

  always_comb begin
    selWait = '0;
    selData = '0;
    selRdy  = 1'b0;
    for (int i = 0; i < NUM_REGIONS; i++) begin
      if (oSel[i]) begin
        selWait = selWait | iRegWait[i];
        selData = selData | iSlvData[i];
        selRdy  = selRdy  | iSlvReady[i];
      end
    end
    if (!(|oSel)) begin
      selData = iDefData;
      selRdy  = 1'b1;
    end
  end

`ifdef BUS_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT + 1);
  logic [TO_W-1:0] toCnt;
`endif

  // ---- FSM next state ----
  always_comb begin
    stateNext = state;
    latch     = 1'b0;
    startWait = 1'b0;
    forceDone = 1'b0;
    case (state)
      ST_IDLE: begin
        if (iAle) begin
          latch     = 1'b1;
          stateNext = ST_ADDR;
        end
      end
      ST_ADDR: begin
        // ALE takes precedence; a coincident strobe edge is lost.
        if (iAle) begin
          latch = 1'b1;
        end else if (strbRise) begin
          startWait = 1'b1;
          stateNext = ST_WAIT;
        end
      end
      ST_WAIT: begin
        // The WAIT entry cycle counts as the first wait state, so the count
        // is spent once it reaches 1 (or was loaded as 0).
        if (!strbAct) begin
          stateNext = ST_IDLE;
        end else if ((cnt <= WAIT_W'(1)) && selRdy) begin
          stateNext = ST_DONE;
        end
`ifdef BUS_TIMEOUT_EN
        else if (toCnt == TO_W'(TIMEOUT - 1)) begin
          forceDone = 1'b1;
          stateNext = ST_DONE;
        end
`endif
      end
      ST_DONE: begin
        if (iAle) begin
          latch     = 1'b1;
          stateNext = ST_ADDR;
        end else if (!strbAct) begin
          stateNext = ST_IDLE;
        end
      end
      default: stateNext = ST_IDLE;
    endcase
  end

  // ---- state and registered outputs ----
  always_ff @(posedge iClk) begin
    if (iRst) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      strbPrev <= 1'b0;
      oAddr    <= '0;
      oSel     <= '0;
      oDefSel  <= 1'b0;
      oReady   <= 1'b1;
      oRdData  <= '0;
    end else begin
      state    <= stateNext;
      strbPrev <= strbAct;
      oReady   <= (stateNext != ST_WAIT);
      if (latch) begin
        oAddr   <= iAd;
        oSel    <= selNext;
        oDefSel <= defNext;
      end
      if (startWait)
        cnt <= selWait;
      else if ((state == ST_WAIT) && (cnt != '0))
        cnt <= cnt - WAIT_W'(1);
      if (forceDone)
        oRdData <= {DATA_W{TIMEOUT_RD_BIT}};
      else if (rdAct && !rdHold)
        oRdData <= selData;
    end
  end

`ifdef BUS_TIMEOUT_EN
  // rdHold keeps the all-ones timeout data from being overwritten while the
  // CPU finishes the timed-out read.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      toCnt    <= '0;
      oTimeout <= 1'b0;
      rdHold   <= 1'b0;
    end else begin
      if (startWait)
        toCnt <= '0;
      else if (state == ST_WAIT)
        toCnt <= toCnt + TO_W'(1);
      oTimeout <= forceDone;
      rdHold   <= forceDone | (rdHold & (stateNext == ST_DONE));
    end
  end
`else
  logic unusedTimeout;
  assign unusedTimeout = ^TIMEOUT;
  assign oTimeout      = 1'b0;
  assign rdHold        = 1'b0;
`endif

endmodule
